// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, FSM states,
// instruction classes and datapath select codes.
package mc_control_fsm_pkg;

  localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
  localparam logic [6:0] OPCODE_OP      = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPCODE_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_CUSTOM, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_LOAD, C_STORE, C_OP, C_OPIMM, C_BRANCH, C_JAL, C_JALR,
    C_LUI, C_AUIPC, C_CUSTOM, C_SYSTEM
  } class_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_ALU    = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] SRC_A_RS1 = 2'd0;
  localparam logic [1:0] SRC_A_PC  = 2'd1;

  localparam logic [1:0] SRC_B_RS2 = 2'd0;
  localparam logic [1:0] SRC_B_IMM = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_CMP   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;
  localparam logic [1:0] WB_IMM    = 2'd3;

  localparam logic [1:0] TC_ILLEGAL  = 2'd0;
  localparam logic [1:0] TC_FETCH_TO = 2'd1;
  localparam logic [1:0] TC_DATA_TO  = 2'd2;
  localparam logic [1:0] TC_SYSTEM   = 2'd3;

  function automatic logic [1:0] wb_code(class_t c);
    case (c)
      C_LOAD:         wb_code = WB_MEM;
      C_JAL, C_JALR:  wb_code = WB_PC4;
      C_LUI:          wb_code = WB_IMM;
      default:        wb_code = WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_opcode_classifier.sv
// Combinational opcode/funct3 classifier. SYSTEM with funct3==0 (ecall/ebreak) is
// reported as its own class; CSR forms are unsupported and flagged illegal.
module mc_opcode_classifier
  import mc_control_fsm_pkg::*;
#(
  parameter int ENABLE_CUSTOM = 1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output class_t     cls,
  output logic       legal
);

  always_comb begin
    cls   = C_NONE;
    legal = 1'b1;
    case (opcode)
      OPCODE_LOAD:    cls = C_LOAD;
      OPCODE_STORE:   cls = C_STORE;
      OPCODE_OP:      cls = C_OP;
      OPCODE_OPIMM:   cls = C_OPIMM;
      OPCODE_BRANCH:  cls = C_BRANCH;
      OPCODE_JAL:     cls = C_JAL;
      OPCODE_JALR:    cls = C_JALR;
      OPCODE_LUI:     cls = C_LUI;
      OPCODE_AUIPC:   cls = C_AUIPC;
      OPCODE_CUSTOM0: begin
        cls   = C_CUSTOM;
        legal = (ENABLE_CUSTOM != 0);
      end
      OPCODE_SYSTEM: begin
        cls   = C_SYSTEM;
        legal = (funct3 == 3'b000);
      end
      default:        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory ready
// handshake with timeout, multi-cycle custom-0 ops and sticky traps.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int ENABLE_CUSTOM = 1,
  parameter int CUSTOM_CYCLES = 4,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       reg_write,
  output logic       custom_start,
  output logic       busy,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int CMAX = (CUSTOM_CYCLES > MEM_TIMEOUT) ? CUSTOM_CYCLES : MEM_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] CUS_LAST = CW'(CUSTOM_CYCLES - 1);

  state_t        state, state_d;
  class_t        cls_q, cls_d, dec_cls;
  logic          dec_legal;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    cause_q, cause_d;

  mc_opcode_classifier #(.ENABLE_CUSTOM(ENABLE_CUSTOM)) u_classifier (
    .opcode (opcode),
    .funct3 (funct3),
    .cls    (dec_cls),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cls_q   <= C_NONE;
      cnt     <= '0;
      cause_q <= TC_ILLEGAL;
    end else begin
      state   <= state_d;
      cls_q   <= cls_d;
      cnt     <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign busy = (state != S_IDLE) && (state != S_TRAP);

  // The counter only advances while staying in a waiting state, so every entry
  // into FETCH/MEM/CUSTOM starts it from zero and TRAP never wraps it.
  always_comb begin
    state_d      = state;
    cls_d        = cls_q;
    cause_d      = cause_q;
    cnt_d        = '0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    addr_sel     = 1'b0;
    alu_src_a    = SRC_A_RS1;
    alu_src_b    = SRC_B_RS2;
    alu_op       = ALU_ADD;
    wb_sel       = WB_ALU;
    reg_write    = 1'b0;
    custom_start = 1'b0;
    trap         = 1'b0;
    trap_cause   = TC_ILLEGAL;

    case (state)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (cnt == TO_LAST) begin
          state_d = S_TRAP;
          cause_d = TC_FETCH_TO;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      S_DECODE: begin
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_IMM;
        cls_d     = dec_cls;
        if (!dec_legal) begin
          state_d = S_TRAP;
          cause_d = TC_ILLEGAL;
        end else if (dec_cls == C_SYSTEM) begin
          state_d = S_TRAP;
          cause_d = TC_SYSTEM;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_WB;
        case (cls_q)
          C_LOAD, C_STORE: begin
            alu_src_b = SRC_B_IMM;
            state_d   = S_MEM;
          end
          C_OP:    alu_op = ALU_FUNCT;
          C_OPIMM: begin
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_FUNCT;
          end
          C_BRANCH: begin
            alu_op   = ALU_CMP;
            pc_write = branch_taken;
            pc_src   = PC_ALU;
            state_d  = S_FETCH;
          end
          C_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_ALU;
          end
          C_JALR: begin
            alu_src_b = SRC_B_IMM;
            pc_write  = 1'b1;
            pc_src    = PC_JALR;
          end
          C_AUIPC: begin
            alu_src_a = SRC_A_PC;
            alu_src_b = SRC_B_IMM;
          end
          C_CUSTOM: state_d = S_CUSTOM;
          default:  ;
        endcase
      end

      S_MEM: begin
        addr_sel  = 1'b1;
        mem_read  = (cls_q == C_LOAD);
        mem_write = (cls_q == C_STORE);
        if (mem_ready) begin
          state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
        end else if (cnt == TO_LAST) begin
          state_d = S_TRAP;
          cause_d = TC_DATA_TO;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = wb_code(cls_q);
        state_d   = S_FETCH;
      end

      S_CUSTOM: begin
        custom_start = (cnt == '0);
        if (cnt == CUS_LAST) state_d = S_WB;
        else                 cnt_d   = cnt + CW'(1);
      end

      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench: an instruction-level model expands each instruction into its
// expected per-cycle output vectors, which are replayed against the DUT.
module tb_mc_control_fsm;

  localparam int CC = 4;
  localparam int TO = 15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_CUSTOM = 7'b0001011;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       addr_sel;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic [1:0] wb;
    logic       reg_write;
    logic       custom_start;
    logic       busy;
    logic       trap;
    logic [1:0] cause;
  } out_t;

  typedef struct {
    logic       rdy;
    logic       bt;
    logic [6:0] op;
    logic [2:0] f3;
    out_t       exp;
    string      tag;
  } cyc_t;

  logic       clk, rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_ready, branch_taken;
  logic       pc_write, ir_write, mem_read, mem_write, addr_sel;
  logic       reg_write, custom_start, busy, trap;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel, trap_cause;
  logic       nc_pc_write, nc_ir_write, nc_mem_read, nc_mem_write, nc_addr_sel;
  logic       nc_reg_write, nc_custom_start, nc_busy, nc_trap;
  logic [1:0] nc_pc_src, nc_alu_src_a, nc_alu_src_b, nc_alu_op, nc_wb_sel, nc_trap_cause;
  out_t       outs, nc_outs;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_instr = 0;
  cyc_t q[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;

  mc_control_fsm #(.ENABLE_CUSTOM(1), .CUSTOM_CYCLES(CC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .wb_sel(wb_sel), .reg_write(reg_write),
    .custom_start(custom_start), .busy(busy), .trap(trap), .trap_cause(trap_cause)
  );

  mc_control_fsm #(.ENABLE_CUSTOM(0), .CUSTOM_CYCLES(CC), .MEM_TIMEOUT(TO)) u_nc (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(nc_pc_write), .pc_src(nc_pc_src),
    .ir_write(nc_ir_write), .mem_read(nc_mem_read), .mem_write(nc_mem_write),
    .addr_sel(nc_addr_sel), .alu_src_a(nc_alu_src_a), .alu_src_b(nc_alu_src_b),
    .alu_op(nc_alu_op), .wb_sel(nc_wb_sel), .reg_write(nc_reg_write),
    .custom_start(nc_custom_start), .busy(nc_busy), .trap(nc_trap), .trap_cause(nc_trap_cause)
  );

  assign outs = {pc_write, pc_src, ir_write, mem_read, mem_write, addr_sel, alu_src_a,
                 alu_src_b, alu_op, wb_sel, reg_write, custom_start, busy, trap, trap_cause};
  assign nc_outs = {nc_pc_write, nc_pc_src, nc_ir_write, nc_mem_read, nc_mem_write, nc_addr_sel,
                    nc_alu_src_a, nc_alu_src_b, nc_alu_op, nc_wb_sel, nc_reg_write,
                    nc_custom_start, nc_busy, nc_trap, nc_trap_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- expected output vectors per phase ----------------
  function automatic out_t fetch_out(logic rdy);
    out_t o = '0;
    o.busy = 1; o.mem_read = 1; o.a = 2'd1; o.b = 2'd2;
    o.ir_write = rdy; o.pc_write = rdy;
    return o;
  endfunction

  function automatic out_t decode_out();
    out_t o = '0;
    o.busy = 1; o.a = 2'd1; o.b = 2'd1;
    return o;
  endfunction

  function automatic out_t exec_out(logic [6:0] op, logic bt);
    out_t o = '0;
    o.busy = 1;
    case (op)
      OP_LOAD, OP_STORE: o.b = 2'd1;
      OP_OP:     o.op = 2'd2;
      OP_OPIMM:  begin o.b = 2'd1; o.op = 2'd2; end
      OP_BRANCH: begin o.op = 2'd1; o.pc_write = bt; o.pc_src = 2'd1; end
      OP_JAL:    begin o.pc_write = 1; o.pc_src = 2'd1; end
      OP_JALR:   begin o.b = 2'd1; o.pc_write = 1; o.pc_src = 2'd2; end
      OP_AUIPC:  begin o.a = 2'd1; o.b = 2'd1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t mem_out(logic is_store);
    out_t o = '0;
    o.busy = 1; o.addr_sel = 1; o.mem_read = !is_store; o.mem_write = is_store;
    return o;
  endfunction

  function automatic out_t wb_out(logic [1:0] sel);
    out_t o = '0;
    o.busy = 1; o.reg_write = 1; o.wb = sel;
    return o;
  endfunction

  function automatic out_t custom_out(logic first);
    out_t o = '0;
    o.busy = 1; o.custom_start = first;
    return o;
  endfunction

  function automatic out_t trap_out(logic [1:0] c);
    out_t o = '0;
    o.trap = 1; o.cause = c;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // ---------------- instruction-level model ----------------
  task automatic add(input logic rdy, input logic bt, input out_t e, input string ph);
    cyc_t c;
    c.rdy = rdy; c.bt = bt; c.op = cur_op; c.f3 = cur_f3; c.exp = e;
    c.tag = $sformatf("i%0d_%s", n_instr, ph);
    q.push_back(c);
  endtask

  task automatic add_trap(input logic [1:0] c);
    for (int i = 0; i < 3; i++) add(rb(), rb(), trap_out(c), "trap");
  endtask

  task automatic model_instr(input logic [6:0] op, input logic [2:0] f3,
                             input int fd, input int md, input logic bt);
    int w;
    logic st;
    n_instr++;
    cur_op = op;
    cur_f3 = f3;
    w = 0;
    while (w < fd && w < TO) begin
      add(1'b0, rb(), fetch_out(1'b0), "fetch_wait");
      w++;
    end
    if (w == TO) begin add_trap(2'd1); return; end
    add(1'b1, rb(), fetch_out(1'b1), "fetch");
    add(rb(), rb(), decode_out(), "decode");
    if (op == OP_SYSTEM) begin add_trap((f3 == 3'd0) ? 2'd3 : 2'd0); return; end
    if (!(op inside {OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_BRANCH, OP_JAL, OP_JALR,
                     OP_LUI, OP_AUIPC, OP_CUSTOM})) begin
      add_trap(2'd0);
      return;
    end
    add(rb(), bt, exec_out(op, bt), "exec");
    case (op)
      OP_LOAD, OP_STORE: begin
        st = (op == OP_STORE);
        w = 0;
        while (w < md && w < TO) begin
          add(1'b0, rb(), mem_out(st), "mem_wait");
          w++;
        end
        if (w == TO) begin add_trap(2'd2); return; end
        add(1'b1, rb(), mem_out(st), "mem");
        if (!st) add(rb(), rb(), wb_out(2'd1), "wb");
      end
      OP_BRANCH: ;
      OP_JAL, OP_JALR: add(rb(), rb(), wb_out(2'd2), "wb");
      OP_LUI:          add(rb(), rb(), wb_out(2'd3), "wb");
      OP_CUSTOM: begin
        for (int i = 0; i < CC; i++) add(rb(), rb(), custom_out(i == 0), "custom");
        add(rb(), rb(), wb_out(2'd0), "wb");
      end
      default:         add(rb(), rb(), wb_out(2'd0), "wb");
    endcase
  endtask

  // ---------------- driver / checker ----------------
  task automatic check(input string tag, input out_t got, input out_t exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_queue(input int n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      @(posedge clk);
      #1;
      mem_ready    = q[i].rdy;
      branch_taken = q[i].bt;
      opcode       = q[i].op;
      funct3       = q[i].f3;
      @(negedge clk);
      check(q[i].tag, outs, q[i].exp);
    end
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset", outs, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle", outs, '0);
  endtask

  initial begin
    logic [6:0] op;
    logic [6:0] legal_ops [10];
    legal_ops = '{OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_BRANCH, OP_JAL, OP_JALR,
                  OP_LUI, OP_AUIPC, OP_CUSTOM};
    rst = 1'b1; opcode = '0; funct3 = '0; mem_ready = 1'b0; branch_taken = 1'b0;

    // Directed: fetch after two wait cycles, LW with ready delay 2, branches both ways
    do_reset();
    model_instr(OP_LOAD, 3'd2, 2, 2, 1'b0);
    model_instr(OP_BRANCH, 3'd0, 0, 0, 1'b1);
    model_instr(OP_BRANCH, 3'd1, 1, 0, 1'b0);
    model_instr(OP_STORE, 3'd2, 0, 3, 1'b0);
    run_queue(q.size());

    // Custom op on both instances: legal here, illegal (cause 0) when disabled
    do_reset();
    model_instr(OP_CUSTOM, 3'd0, 0, 0, 1'b0);
    run_queue(q.size());
    check("nc_custom_trap", nc_outs, trap_out(2'd0));

    // Timeout boundaries: ready on the last allowed cycle wins, one more cycle traps
    do_reset();
    model_instr(OP_OP, 3'd0, TO - 1, 0, 1'b0);
    model_instr(OP_LOAD, 3'd0, 0, TO - 1, 1'b0);
    model_instr(OP_OPIMM, 3'd0, TO, 0, 1'b0);
    run_queue(q.size());
    do_reset();
    model_instr(OP_STORE, 3'd0, 0, TO, 1'b0);
    run_queue(q.size());

    // SYSTEM traps (ecall/ebreak cause 3, CSR forms illegal)
    do_reset();
    model_instr(OP_SYSTEM, 3'd0, 1, 0, 1'b0);
    run_queue(q.size());
    do_reset();
    model_instr(OP_SYSTEM, 3'd1, 0, 0, 1'b0);
    run_queue(q.size());

    // Random illegal opcodes
    for (int k = 0; k < 3; k++) begin
      do begin
        op = 7'($urandom);
      end while (op inside {OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_BRANCH, OP_JAL, OP_JALR,
                            OP_LUI, OP_AUIPC, OP_CUSTOM, OP_SYSTEM});
      do_reset();
      model_instr(op, 3'($urandom), $urandom_range(0, 3), 0, 1'b0);
      run_queue(q.size());
    end

    // Reset in the middle of a store's data phase drops mem_write at once
    do_reset();
    model_instr(OP_STORE, 3'd2, 0, 6, 1'b0);
    run_queue(4);
    #1 rst = 1'b1;
    #1 check("rst_mid_store", outs, '0);

    // Random legal instruction stream
    do_reset();
    for (int k = 0; k < 40; k++) begin
      model_instr(legal_ops[$urandom_range(0, 9)], 3'($urandom), $urandom_range(0, 4),
                  $urandom_range(0, 4), rb());
    end
    run_queue(q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
